// File: rtl/ulpi_pkg.sv
// Shared ULPI link definitions: TX CMD prefixes, the extended-address
// escape code, RX CMD field positions and the register-access FSM states.
// ULPI_EXT_REG_EN adds the EXT_ADDR state used for extended register access.
package ulpi_pkg;

  localparam logic [1:0] REG_WR       = 2'b10;
  localparam logic [1:0] REG_RD       = 2'b11;
  localparam logic [5:0] EXT_ADDR_ESC = 6'h2F;

  // RX CMD byte fields
  localparam int LINESTATE_LSB = 0;
  localparam int LINESTATE_MSB = 1;
  localparam int RXEVENT_LSB   = 4;
  localparam int RXEVENT_MSB   = 5;

  localparam logic [1:0] RXEVENT_ACTIVE = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_WDATA,
    ST_STP,
    ST_RD_TA,
    ST_RD_DATA,
    ST_WAIT_DIR
`ifdef ULPI_EXT_REG_EN
    , ST_EXT_ADDR
`endif
  } ulpi_state_e;

  function automatic logic [7:0] tx_cmd(input logic wr, input logic [5:0] addr);
    return {(wr ? REG_WR : REG_RD), addr};
  endfunction

  function automatic logic [1:0] rx_event(input logic [7:0] cmd);
    return cmd[RXEVENT_MSB:RXEVENT_LSB];
  endfunction

endpackage

// File: rtl/ulpi_link_ctrl_if.sv
// Bus bundle between the ULPI link controller, the ULPI pads and the core.
// master = link controller, slave = PHY pads plus USB core.
//
// Handshakes: reg_req is a level request that the core holds (with reg_wr,
// reg_addr, reg_wdata stable) until it sees a one-cycle reg_ack or
// reg_abort; the controller latches the request when it starts, so dropping
// reg_req early does not cancel an access. rx_cmd_valid / rx_data_valid are
// one-cycle valid pulses with no ready: the core must take the byte that
// cycle. rx_cmd holds the last RX CMD between pulses.
interface ulpi_link_ctrl_if #(
  parameter int OE_W = 8
);
  logic [7:0]      ulpi_data_read;
  logic [7:0]      ulpi_data_write;
  logic [OE_W-1:0] ulpi_data_writeEnable;
  logic            ulpi_direction;
  logic            ulpi_nxt;
  logic            ulpi_stp;

  logic            reg_req;
  logic            reg_wr;
  logic [7:0]      reg_addr;
  logic [7:0]      reg_wdata;
  logic            reg_ack;
  logic            reg_abort;
  logic [7:0]      reg_rdata;

  logic            rx_cmd_valid;
  logic [7:0]      rx_cmd;
  logic            rx_data_valid;
  logic [7:0]      rx_data;
  logic            rx_active;

  modport master (
    input  ulpi_data_read, ulpi_direction, ulpi_nxt,
    input  reg_req, reg_wr, reg_addr, reg_wdata,
    output ulpi_data_write, ulpi_data_writeEnable, ulpi_stp,
    output reg_ack, reg_abort, reg_rdata,
    output rx_cmd_valid, rx_cmd, rx_data_valid, rx_data, rx_active
  );

  modport slave (
    output ulpi_data_read, ulpi_direction, ulpi_nxt,
    output reg_req, reg_wr, reg_addr, reg_wdata,
    input  ulpi_data_write, ulpi_data_writeEnable, ulpi_stp,
    input  reg_ack, reg_abort, reg_rdata,
    input  rx_cmd_valid, rx_cmd, rx_data_valid, rx_data, rx_active
  );
endinterface

// File: rtl/ulpi_rx_demux.sv
// Turnaround tracking and RX CMD / RX data capture for the ULPI link.
// A turnaround cycle is any cycle in which dir differs from its value in
// the previous cycle; such cycles are never sampled.
module ulpi_rx_demux
  import ulpi_pkg::*;
(
  input  logic       clk,
  input  logic       reset_,
  input  logic       dir,
  input  logic       nxt,
  input  logic [7:0] data,
  input  logic       suppress,   // FSM is consuming this byte as register read data
  output logic       ta,
  output logic       cmd_valid,
  output logic [7:0] cmd,
  output logic       data_valid,
  output logic [7:0] rx_data,
  output logic       active
);

  logic dir_q;

  assign ta     = dir ^ dir_q;
  assign active = (rx_event(cmd) == RXEVENT_ACTIVE) & dir;

  // Demultiplex PHY-owned bus cycles into RX CMD and RX data bytes
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      dir_q      <= 1'b0;
      cmd_valid  <= 1'b0;
      cmd        <= 8'h00;
      data_valid <= 1'b0;
      rx_data    <= 8'h00;
    end else begin
      dir_q      <= dir;
      cmd_valid  <= 1'b0;
      data_valid <= 1'b0;
      if (dir && !ta && !suppress) begin
        if (nxt) begin
          rx_data    <= data;
          data_valid <= 1'b1;
        end else begin
          cmd        <= data;
          cmd_valid  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ulpi_link_ctrl.sv
// Link-side ULPI controller: register-access FSM with nxt timeout, bus
// turnaround handling and pad drive-enable fan-out. RX demux is in
// ulpi_rx_demux. Define ULPI_EXT_REG_EN to enable extended register
// addressing (addresses above 0x2E go through the 0x2F escape byte).
module ulpi_link_ctrl
  import ulpi_pkg::*;
#(
  parameter int OE_W        = 8,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic             clk,
  input  logic             reset_,
  ulpi_link_ctrl_if.master bus,
  output ulpi_state_e      state_dbg
);

  localparam int                CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  ulpi_state_e      state_q;
  logic             drive_q;
  logic [7:0]       data_q;
  logic             stp_q;
  logic             ack_q;
  logic             abort_q;
  logic [7:0]       rdata_q;
  logic [CNT_W-1:0] cnt_q;
  logic             wr_q;
  logic [7:0]       wdata_q;
  logic             ta;
  logic             oe;
  logic             rd_consume;

`ifdef ULPI_EXT_REG_EN
  logic             ext_q;
  logic [7:0]       ext_addr_q;
`else
  logic             unused_addr_hi;
  assign unused_addr_hi = ^bus.reg_addr[7:6];
`endif

  // The pad must release in the very cycle the PHY takes the bus
  assign oe                        = drive_q & ~bus.ulpi_direction;
  assign bus.ulpi_data_writeEnable = {OE_W{oe}};
  assign bus.ulpi_data_write       = oe ? data_q : 8'h00;
  assign bus.ulpi_stp              = stp_q;
  assign bus.reg_ack               = ack_q;
  assign bus.reg_abort             = abort_q;
  assign bus.reg_rdata             = rdata_q;
  assign state_dbg                 = state_q;

  // The register-read byte is not an RX CMD; an interleaved (nxt=1) byte is RX data
  assign rd_consume = (state_q == ST_RD_DATA) & ~bus.ulpi_nxt;

  ulpi_rx_demux u_rx_demux (
    .clk        (clk),
    .reset_     (reset_),
    .dir        (bus.ulpi_direction),
    .nxt        (bus.ulpi_nxt),
    .data       (bus.ulpi_data_read),
    .suppress   (rd_consume),
    .ta         (ta),
    .cmd_valid  (bus.rx_cmd_valid),
    .cmd        (bus.rx_cmd),
    .data_valid (bus.rx_data_valid),
    .rx_data    (bus.rx_data),
    .active     (bus.rx_active)
  );

  // Register-access FSM with registered bus and handshake outputs
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q    <= ST_IDLE;
      drive_q    <= 1'b0;
      data_q     <= 8'h00;
      stp_q      <= 1'b0;
      ack_q      <= 1'b0;
      abort_q    <= 1'b0;
      rdata_q    <= 8'h00;
      cnt_q      <= '0;
      wr_q       <= 1'b0;
      wdata_q    <= 8'h00;
`ifdef ULPI_EXT_REG_EN
      ext_q      <= 1'b0;
      ext_addr_q <= 8'h00;
`endif
    end else begin
      ack_q   <= 1'b0;
      abort_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          stp_q   <= 1'b0;
          drive_q <= 1'b0;
          data_q  <= 8'h00;
          if (bus.reg_req && !bus.ulpi_direction && !ta) begin
            wr_q    <= bus.reg_wr;
            wdata_q <= bus.reg_wdata;
            cnt_q   <= '0;
            drive_q <= 1'b1;
            state_q <= ST_CMD;
`ifdef ULPI_EXT_REG_EN
            ext_addr_q <= bus.reg_addr;
            if (bus.reg_addr > 8'h2E) begin
              ext_q  <= 1'b1;
              data_q <= tx_cmd(bus.reg_wr, EXT_ADDR_ESC);
            end else begin
              ext_q  <= 1'b0;
              data_q <= tx_cmd(bus.reg_wr, bus.reg_addr[5:0]);
            end
`else
            data_q <= tx_cmd(bus.reg_wr, bus.reg_addr[5:0]);
`endif
          end
        end

        ST_CMD, ST_WDATA
`ifdef ULPI_EXT_REG_EN
        , ST_EXT_ADDR
`endif
        : begin
          if (bus.ulpi_direction) begin
            // PHY grabbed the bus before accepting our byte
            abort_q <= 1'b1;
            drive_q <= 1'b0;
            data_q  <= 8'h00;
            state_q <= ST_WAIT_DIR;
          end else if (bus.ulpi_nxt) begin
            cnt_q <= '0;
            if (state_q == ST_WDATA) begin
              data_q  <= 8'h00;
              stp_q   <= 1'b1;
              state_q <= ST_STP;
`ifdef ULPI_EXT_REG_EN
            end else if (state_q == ST_CMD && ext_q) begin
              data_q  <= ext_addr_q;
              state_q <= ST_EXT_ADDR;
`endif
            end else if (wr_q) begin
              data_q  <= wdata_q;
              state_q <= ST_WDATA;
            end else begin
              drive_q <= 1'b0;
              data_q  <= 8'h00;
              state_q <= ST_RD_TA;
            end
          end else if (cnt_q == CNT_LAST) begin
            // PHY never accepted: stop the transfer, bus released from IDLE
            stp_q   <= 1'b1;
            data_q  <= 8'h00;
            abort_q <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_STP: begin
          stp_q   <= 1'b0;
          drive_q <= 1'b0;
          data_q  <= 8'h00;
          ack_q   <= 1'b1;
          state_q <= ST_IDLE;
        end

        ST_RD_TA: begin
          if (bus.ulpi_direction) begin
            state_q <= ST_RD_DATA;
          end else begin
            abort_q <= 1'b1;
            state_q <= ST_WAIT_DIR;
          end
        end

        ST_RD_DATA: begin
          if (bus.ulpi_nxt || !bus.ulpi_direction) begin
            abort_q <= 1'b1;
          end else begin
            rdata_q <= bus.ulpi_data_read;
            ack_q   <= 1'b1;
          end
          state_q <= ST_WAIT_DIR;
        end

        ST_WAIT_DIR: begin
          drive_q <= 1'b0;
          stp_q   <= 1'b0;
          data_q  <= 8'h00;
          if (!bus.ulpi_direction && !ta) state_q <= ST_IDLE;
        end

        default: begin
          drive_q <= 1'b0;
          stp_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ulpi_link_ctrl.sv
// Directed bench for ulpi_link_ctrl: RX demux vector table plus
// hand-written register write/read, abort, timeout and reset sequences.
module tb_ulpi_link_ctrl;
  import ulpi_pkg::*;

  localparam int OE_W = 8;
  localparam int TO   = 4;

  logic        clk = 1'b0;
  logic        reset_;
  ulpi_state_e state_dbg;

  ulpi_link_ctrl_if #(.OE_W(OE_W)) bus ();

  ulpi_link_ctrl #(.OE_W(OE_W), .TIMEOUT_CYC(TO)) dut (
    .clk       (clk),
    .reset_    (reset_),
    .bus       (bus.master),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic       dir;
    logic       nxt;
    logic [7:0] data;
    logic       cmd_v;
    logic [7:0] cmd;
    logic       dat_v;
    logic [7:0] dat;
    logic       active;
  } rx_vec_t;

  rx_vec_t vecs[7];

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input string name, input ulpi_state_e target, input int max_cyc);
    int n;
    n = 0;
    while (state_dbg != target && n < max_cyc) begin
      tick();
      n++;
    end
    check(name, 32'(state_dbg), 32'(target));
  endtask

  // ---------------- driver tasks ----------------
  task automatic run_write(input string name, input logic [7:0] addr, input logic [7:0] wdata,
                           input int wait_cyc);
    logic [7:0] cmd_b;
    logic [7:0] exp_b;
    int idx;
    cmd_b = {2'b10, addr[5:0]};
`ifdef ULPI_EXT_REG_EN
    if (addr > 8'h2E) cmd_b = 8'hAF;
`endif
    for (int i = 0; i <= wait_cyc; i++) exp_q.push_back(cmd_b);
`ifdef ULPI_EXT_REG_EN
    if (addr > 8'h2E) exp_q.push_back(addr);
`endif
    exp_q.push_back(wdata);
    exp_q.push_back(8'h00);

    bus.reg_req   = 1'b1;
    bus.reg_wr    = 1'b1;
    bus.reg_addr  = addr;
    bus.reg_wdata = wdata;
    bus.ulpi_nxt  = 1'b0;
    tick();
    idx = 0;
    while (exp_q.size() > 0 && idx < 16) begin
      exp_b = exp_q.pop_front();
      check({name, "_byte"}, 32'(bus.ulpi_data_write), 32'(exp_b));
      check({name, "_we"}, 32'(bus.ulpi_data_writeEnable), 'hFF);
      check({name, "_stp"}, 32'(bus.ulpi_stp), 32'(exp_q.size() == 0));
      bus.ulpi_nxt = (idx >= wait_cyc) && (exp_q.size() != 0);
      tick();
      idx++;
    end
    check({name, "_ack"}, 32'(bus.reg_ack), 1);
    check({name, "_abort"}, 32'(bus.reg_abort), 0);
    check({name, "_we_off"}, 32'(bus.ulpi_data_writeEnable), 0);
    check({name, "_data_off"}, 32'(bus.ulpi_data_write), 0);
    bus.reg_req = 1'b0;
    tick();
    check({name, "_ack_pulse"}, 32'(bus.reg_ack), 0);
  endtask

  task automatic run_read(input string name, input logic [7:0] addr, input logic [7:0] phy_data,
                          input logic interleave);
    bus.reg_req  = 1'b1;
    bus.reg_wr   = 1'b0;
    bus.reg_addr = addr;
    tick();
    check({name, "_cmd"}, 32'(bus.ulpi_data_write), 32'({2'b11, addr[5:0]}));
    check({name, "_we"}, 32'(bus.ulpi_data_writeEnable), 'hFF);
    bus.ulpi_nxt = 1'b1;
    tick();
    check({name, "_release"}, 32'(bus.ulpi_data_writeEnable), 0);
    bus.ulpi_nxt       = 1'b0;
    bus.ulpi_direction = 1'b1;
    bus.ulpi_data_read = 8'hEE;
    tick();
    check({name, "_ta_no_rxcmd"}, 32'(bus.rx_cmd_valid), 0);
    bus.ulpi_data_read = phy_data;
    bus.ulpi_nxt       = interleave;
    tick();
    if (!interleave) begin
      check({name, "_ack"}, 32'(bus.reg_ack), 1);
      check({name, "_rdata"}, 32'(bus.reg_rdata), 32'(phy_data));
      check({name, "_abort"}, 32'(bus.reg_abort), 0);
      check({name, "_no_rxcmd"}, 32'(bus.rx_cmd_valid), 0);
    end else begin
      check({name, "_abort"}, 32'(bus.reg_abort), 1);
      check({name, "_ack"}, 32'(bus.reg_ack), 0);
      check({name, "_rxdata_v"}, 32'(bus.rx_data_valid), 1);
      check({name, "_rxdata"}, 32'(bus.rx_data), 32'(phy_data));
    end
    bus.reg_req        = 1'b0;
    bus.ulpi_nxt       = 1'b0;
    bus.ulpi_direction = 1'b0;
    wait_state({name, "_idle"}, ST_IDLE, 8);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset_             = 1'b0;
    bus.ulpi_data_read = 8'h00;
    bus.ulpi_direction = 1'b0;
    bus.ulpi_nxt       = 1'b0;
    bus.reg_req        = 1'b0;
    bus.reg_wr         = 1'b0;
    bus.reg_addr       = 8'h00;
    bus.reg_wdata      = 8'h00;

    vecs[0] = '{1'b1, 1'b0, 8'hFF, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 8'h10, 1'b1, 8'h10, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 8'hC3, 1'b0, 8'h10, 1'b1, 8'hC3, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 8'h01, 1'b0, 8'h10, 1'b1, 8'h01, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 8'h01, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 8'h5A, 1'b0, 8'h00, 1'b0, 8'h01, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h01, 1'b0};

    repeat (3) tick();
    check("rst_data", 32'(bus.ulpi_data_write), 0);
    check("rst_we", 32'(bus.ulpi_data_writeEnable), 0);
    check("rst_stp", 32'(bus.ulpi_stp), 0);
    check("rst_ack", 32'(bus.reg_ack), 0);
    check("rst_abort", 32'(bus.reg_abort), 0);
    check("rst_rdata", 32'(bus.reg_rdata), 0);
    check("rst_cmd_v", 32'(bus.rx_cmd_valid), 0);
    check("rst_cmd", 32'(bus.rx_cmd), 0);
    check("rst_dat_v", 32'(bus.rx_data_valid), 0);
    check("rst_dat", 32'(bus.rx_data), 0);
    check("rst_active", 32'(bus.rx_active), 0);
    check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    reset_ = 1'b1;
    tick();

    // RX packet: turnaround, RX CMD, two data bytes, closing RX CMD, turnaround
    for (int i = 0; i < 7; i++) begin
      bus.ulpi_direction = vecs[i].dir;
      bus.ulpi_nxt       = vecs[i].nxt;
      bus.ulpi_data_read = vecs[i].data;
      tick();
      check($sformatf("rx%0d_cmd_v", i), 32'(bus.rx_cmd_valid), 32'(vecs[i].cmd_v));
      check($sformatf("rx%0d_cmd", i), 32'(bus.rx_cmd), 32'(vecs[i].cmd));
      check($sformatf("rx%0d_dat_v", i), 32'(bus.rx_data_valid), 32'(vecs[i].dat_v));
      check($sformatf("rx%0d_dat", i), 32'(bus.rx_data), 32'(vecs[i].dat));
      check($sformatf("rx%0d_active", i), 32'(bus.rx_active), 32'(vecs[i].active));
      check($sformatf("rx%0d_we", i), 32'(bus.ulpi_data_writeEnable), 0);
    end

    // Register write with nxt withheld for the first driven cycle
    run_write("wr0a", 8'h0A, 8'h55, 1);

    // Register read, then read lost to interleaved RX data
    run_read("rd16", 8'h16, 8'hA3, 1'b0);
    run_read("rd_il", 8'h05, 8'h3C, 1'b1);

    // dir rises while the TX CMD is on the bus
    bus.reg_req   = 1'b1;
    bus.reg_wr    = 1'b1;
    bus.reg_addr  = 8'h0A;
    bus.reg_wdata = 8'h11;
    tick();
    check("dirab_cmd", 32'(bus.ulpi_data_write), 'h8A);
    bus.ulpi_direction = 1'b1;
    bus.ulpi_data_read = 8'h4D;
    #1;
    check("dirab_we_same_cycle", 32'(bus.ulpi_data_writeEnable), 0);
    check("dirab_data_same_cycle", 32'(bus.ulpi_data_write), 0);
    tick();
    check("dirab_abort", 32'(bus.reg_abort), 1);
    check("dirab_ack", 32'(bus.reg_ack), 0);
    check("dirab_ta_no_rxcmd", 32'(bus.rx_cmd_valid), 0);
    bus.reg_req = 1'b0;
    tick();
    check("dirab_abort_pulse", 32'(bus.reg_abort), 0);
    check("dirab_cmd_v", 32'(bus.rx_cmd_valid), 1);
    check("dirab_rxcmd", 32'(bus.rx_cmd), 'h4D);
    check("dirab_active", 32'(bus.rx_active), 0);
    bus.ulpi_direction = 1'b0;
    wait_state("dirab_idle", ST_IDLE, 8);

    // nxt never comes: timeout after TO cycles of the CMD byte
    bus.reg_req   = 1'b1;
    bus.reg_wr    = 1'b1;
    bus.reg_addr  = 8'h03;
    bus.reg_wdata = 8'h77;
    bus.ulpi_nxt  = 1'b0;
    tick();
    check("to_cmd", 32'(bus.ulpi_data_write), 'h83);
    for (int k = 1; k < TO; k++) begin
      tick();
      check($sformatf("to_wait%0d_stp", k), 32'(bus.ulpi_stp), 0);
      check($sformatf("to_wait%0d_abort", k), 32'(bus.reg_abort), 0);
    end
    tick();
    check("to_stp", 32'(bus.ulpi_stp), 1);
    check("to_abort", 32'(bus.reg_abort), 1);
    check("to_ack", 32'(bus.reg_ack), 0);
    bus.reg_req = 1'b0;
    tick();
    check("to_stp_pulse", 32'(bus.ulpi_stp), 0);
    check("to_abort_pulse", 32'(bus.reg_abort), 0);
    check("to_we_off", 32'(bus.ulpi_data_writeEnable), 0);

`ifdef ULPI_EXT_REG_EN
    run_write("wr_ext80", 8'h80, 8'h12, 0);
`else
    run_write("wr_trunc", 8'hCA, 8'h12, 0);
`endif

    // Async reset mid-access releases the pads at once
    bus.reg_req  = 1'b1;
    bus.reg_wr   = 1'b0;
    bus.reg_addr = 8'h04;
    tick();
    check("arst_we_before", 32'(bus.ulpi_data_writeEnable), 'hFF);
    reset_ = 1'b0;
    #1;
    check("arst_we", 32'(bus.ulpi_data_writeEnable), 0);
    check("arst_state", 32'(state_dbg), 32'(ST_IDLE));
    bus.reg_req = 1'b0;
    tick();
    reset_ = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ulpi_link_ctrl.md
Name: ulpi_link_ctrl

Overview:
Link-side ULPI bus controller between the ULPI pads and the USB core.
- Generalises the current fixed pad-level ULPI hookup: parametrised output-enable fan-out, register-access FSM with timeout, RX CMD / RX data demux, and correct bus turnaround.
- Sits directly behind the ulpi_* top-level pins; the core sees a simple req/ack register port plus RX streams.

Parameters:
- OE_W, 8: width of ulpi_data_writeEnable; all bits are replicas of one drive enable.
- TIMEOUT_CYC, 255: cycles to wait for nxt on any TX CMD/data byte before aborting. Range 1..65535; counter width is clog2(TIMEOUT_CYC+1).

Ports:
- clk  in  1  ULPI 60 MHz clock (from PHY).
- reset_  in  1  async active-low reset.
- ulpi_data_read  in  8  PHY-to-link data.
- ulpi_data_write  out  8  link-to-PHY data.
- ulpi_data_writeEnable  out  OE_W  pad drive enable, all bits equal.
- ulpi_direction  in  1  PHY owns bus when 1.
- ulpi_nxt  in  1  PHY throttle/next.
- ulpi_stp  out  1  link stop.
- reg_req  in  1  register access request, held until reg_ack/reg_abort.
- reg_wr  in  1  1 = write, 0 = read.
- reg_addr  in  8  register address; [7:6] used only with ULPI_EXT_REG_EN.
- reg_wdata  in  8  write data.
- reg_ack  out  1  one-cycle pulse, access complete.
- reg_abort  out  1  one-cycle pulse, access lost to dir or timeout.
- reg_rdata  out  8  read data, valid with reg_ack on reads.
- rx_cmd_valid  out  1  pulse, new RX CMD byte.
- rx_cmd  out  8  last RX CMD byte (held).
- rx_data_valid  out  1  pulse, RX data byte.
- rx_data  out  8  RX data byte.
- rx_active  out  1  rx_cmd[5:4]==2'b01 and dir high.

Behaviour:
- Reset values: all outputs 0; rx_cmd = 8'h00; FSM = IDLE.
- Drive enable: ulpi_data_writeEnable = {OE_W{drive_q & ~ulpi_direction}}. This is combinational on dir so the pad releases in the same cycle dir rises. ulpi_data_write = 8'h00 whenever not driving.
- Turnaround: the first cycle after dir rises and the first cycle after dir falls are ignored. No sampling and no driving occur in those cycles.
- RX, dir=1 and not turnaround:
  - nxt=0: rx_cmd <= data, rx_cmd_valid pulses.
  - nxt=1: rx_data <= data, rx_data_valid pulses.
- FSM states: IDLE, CMD, WDATA, STP, RD_TA, RD_DATA, WAIT_DIR.
- IDLE: on reg_req with dir=0 and not turnaround, drive TX CMD = {reg_wr ? 2'b10 : 2'b11, addr[5:0]} and go to CMD. Reset the timeout counter.
- CMD, nxt=1:
  - Write: drive reg_wdata, go to WDATA.
  - Read: release the bus, go to RD_TA.
- WDATA, nxt=1: drive 8'h00 with stp=1 for one cycle (STP), then pulse reg_ack and return to IDLE.
- RD_TA: expects dir=1 this cycle (turnaround); go to RD_DATA. If dir=0, abort.
- RD_DATA: capture data into reg_rdata, pulse reg_ack, go to WAIT_DIR. If nxt=1 (PHY interleaved RX), abort instead.
- WAIT_DIR: returns to IDLE once dir=0 and turnaround has elapsed.
- Abort:
  - dir rises in CMD or WDATA before nxt: pulse reg_abort, go to WAIT_DIR. The RX path handles the bus.
  - Timeout: TIMEOUT_CYC cycles in CMD or WDATA with nxt=0 → assert stp for one cycle, pulse reg_abort, go to IDLE.
  - The core retries at its own discretion; the controller never auto-retries.
- reg_req deasserted mid-access is ignored; the access completes.
- Async reset mid-access releases the bus immediately (drive_q=0).
- ack and abort are mutually exclusive per access.

Optional Feature:
- Macro ULPI_EXT_REG_EN.
- Defined: if reg_addr > 8'h2E, the TX CMD uses address 6'h2F (extended escape). After nxt, an extra byte reg_addr[7:0] is sent before the data (write) or before the turnaround (read). This adds state EXT_ADDR.
- Undefined: reg_addr[7:6] are ignored, addresses are truncated to 6 bits, and the EXT_ADDR state is absent.

Decomposition:
- Package ulpi_pkg:
  - TX CMD prefixes: REG_WR=2'b10, REG_RD=2'b11.
  - EXT_ADDR_ESC = 6'h2F.
  - RX CMD field positions: linestate [1:0], rxevent [5:4].
  - FSM state enum.
- One natural sub-module, ulpi_rx_demux: turnaround tracking plus RX CMD/data capture. It exports a turnaround flag to the FSM.

Test Plan:
- Write addr 0x0A data 0x55, nxt high on 2nd and 3rd driven cycles → bus shows 0x8A, 0x55, then 0x00 with stp=1; reg_ack one cycle later; writeEnable = 8'hFF only while driving.
- Read addr 0x16: nxt on CMD, dir=1 next cycle, PHY data 0xA3 with nxt=0 → reg_rdata=0xA3, reg_ack pulse, no rx_cmd_valid for the turnaround or data cycle.
- dir rises during CMD before nxt → writeEnable drops in the same cycle, reg_abort pulses; subsequent RX CMD 0x4D gives rx_cmd_valid with rx_cmd=0x4D and rx_active=0.
- nxt held low, TIMEOUT_CYC=4 → stp pulse and reg_abort exactly 4 cycles after the CMD byte is first driven.
- RX packet, dir=1: nxt pattern 0,1,1,0 with data 0x10,0xC3,0x01,0x00 → rx_cmd 0x10, rx_data 0xC3 then 0x01, final rx_cmd 0x00; rx_active=1 between them.
- With ULPI_EXT_REG_EN, write addr 0x80 data 0x12 → bus shows 0xAF, 0x80, 0x12, then stp; reg_ack.
